// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory arbiter slice.
//   MASTER_ID_W  : width of a requester id (two requesters -> 1 bit)
//   DMEM_DATA_W  : default data width of the data memory
//   DMEM_BE_W    : byte-enable width that goes with DMEM_DATA_W
//   master_id_t  : names the two requesters
//   rd_tag_t     : {valid, id} marker carried alongside an outstanding read
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int MASTER_ID_W = 1;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BE_W   = DMEM_DATA_W / 8;

  typedef enum logic [MASTER_ID_W-1:0] {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, id: MASTER_0};

  // The requester that did not win last time; this is the round-robin choice.
  function automatic master_id_t other_master(master_id_t id);
    return (id == MASTER_0) ? MASTER_1 : MASTER_0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Request/grant/read-return bundle between one requester and the arbiter.
//   req    : request, held by the requester until granted
//   we     : byte write enables, all-zero means read
//   addr   : byte address
//   wdata  : write data
//   gnt    : request accepted this cycle (combinational)
//   rvalid : read data valid
//   rdata  : read data
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = DMEM_DATA_W
);

  logic                  req;
  logic [DATA_W/8-1:0]   we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// rd_tag_pipe
// DEPTH-stage shift register of read tags that mirrors the memory read
// latency. It advances every cycle; an asynchronous clear drops every
// in-flight tag.
//   clk     : clock
//   rstn    : asynchronous active-low clear
//   tag_in  : tag entering this cycle (valid=0 for writes and idle cycles)
//   tag_out : tag leaving the pipe, aligned with the memory read data
// ---------------------------------------------------------------------------
module rd_tag_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rstn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RD_TAG_IDLE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between master 0 (load/store unit) and
// master 1 (DMA/debug loader). At most one access is granted per cycle;
// reads are tagged with their issuer and the returning word is steered back
// RD_LATENCY cycles after the grant edge.
//   clk, rstn  : clock, asynchronous active-low reset
//   m0, m1     : requester ports (dmem_arbiter_if.slave)
//   en_mem     : memory enable
//   w_en_mem   : memory byte write enables
//   addr_mem   : memory byte address
//   w_data_mem : memory write data
//   r_data_mem : memory read data (passed straight through to rdata)
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rstn,
  dmem_arbiter_if.slave       m0,
  dmem_arbiter_if.slave       m1,
  output logic                en_mem,
  output logic [DATA_W/8-1:0] w_en_mem,
  output logic [ADDR_W-1:0]   addr_mem,
  output logic [DATA_W-1:0]   w_data_mem,
  input  logic [DATA_W-1:0]   r_data_mem
);

  master_id_t last_gnt;
  logic       sel_m1;
  rd_tag_t    push_tag;
  rd_tag_t    tail_tag;

  // On a tie the fixed-priority build always favours master 0; round-robin
  // hands the port to whoever did not win the previous grant.
  always_comb begin
    sel_m1 = m1.req;
    if (m0.req && m1.req) begin
      sel_m1 = (FIXED_PRIO != 0) ? 1'b0 : (other_master(last_gnt) == MASTER_1);
    end
  end

  // Grants are suppressed while reset is asserted so nothing reaches memory.
  assign m0.gnt = rstn & m0.req & ~sel_m1;
  assign m1.gnt = rstn & m1.req &  sel_m1;

  // With no grant the address/data lines simply follow master 0; only the
  // enables matter then.
  always_comb begin
    en_mem     = m0.gnt | m1.gnt;
    w_en_mem   = '0;
    addr_mem   = m0.addr;
    w_data_mem = m0.wdata;
    push_tag   = RD_TAG_IDLE;
    if (m1.gnt) begin
      w_en_mem   = m1.we;
      addr_mem   = m1.addr;
      w_data_mem = m1.wdata;
      push_tag   = '{valid: (m1.we == '0), id: MASTER_1};
    end else if (m0.gnt) begin
      w_en_mem   = m0.we;
      push_tag   = '{valid: (m0.we == '0), id: MASTER_0};
    end
  end

  // Reset to master 1 so master 0 takes the first tie after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt <= MASTER_1;
    end else if (m1.gnt) begin
      last_gnt <= MASTER_1;
    end else if (m0.gnt) begin
      last_gnt <= MASTER_0;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .tag_in  (push_tag),
    .tag_out (tail_tag)
  );

  assign m0.rvalid = tail_tag.valid && (tail_tag.id == MASTER_0);
  assign m1.rvalid = tail_tag.valid && (tail_tag.id == MASTER_1);
  assign m0.rdata  = r_data_mem;
  assign m1.rdata  = r_data_mem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Two arbiter builds side by side, each with its own behavioural memory:
//   instance 0 : round-robin, read latency 1
//   instance 1 : fixed priority, read latency 2
// Both are checked every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int NI   = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MEMW = 256;

  logic clk;
  logic rstn;

  // Stimulus arrays, indexed [instance][master].
  logic [1:0]    req_in   [NI];
  logic [BW-1:0] we_in    [NI][2];
  logic [AW-1:0] addr_in  [NI][2];
  logic [DW-1:0] wdata_in [NI][2];

  // Observed DUT outputs.
  logic [1:0]    gnt_out    [NI];
  logic [1:0]    rvalid_out [NI];
  logic [DW-1:0] rdata_out  [NI][2];
  logic          en_o       [NI];
  logic [BW-1:0] wen_o      [NI];
  logic [AW-1:0] maddr_o    [NI];
  logic [DW-1:0] mwdata_o   [NI];
  logic [DW-1:0] mrdata_i   [NI];

  // Reference model state.
  typedef struct {
    int          inst;
    int          due;
    int          id;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     exp_q [$];
  logic [31:0] ref_mem  [NI][MEMW];
  int          last_win [NI];
  logic [1:0]  saw_gnt  [NI];
  int          cycle;
  int          total;
  int          bad;

  // Initial memory image; word 8 (byte 0x20) holds a known pattern.
  function automatic logic [31:0] mem_init(int i);
    if (i == 8) return 32'h1122_3344;
    return {16'hC0DE, 8'(i), 8'(~i)};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NI; g++) begin : inst
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

    assign m0_bus.req   = req_in[g][0];
    assign m0_bus.we    = we_in[g][0];
    assign m0_bus.addr  = addr_in[g][0];
    assign m0_bus.wdata = wdata_in[g][0];
    assign m1_bus.req   = req_in[g][1];
    assign m1_bus.we    = we_in[g][1];
    assign m1_bus.addr  = addr_in[g][1];
    assign m1_bus.wdata = wdata_in[g][1];

    assign gnt_out[g]      = {m1_bus.gnt, m0_bus.gnt};
    assign rvalid_out[g]   = {m1_bus.rvalid, m0_bus.rvalid};
    assign rdata_out[g][0] = m0_bus.rdata;
    assign rdata_out[g][1] = m1_bus.rdata;

    dmem_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RD_LATENCY (g + 1),
      .FIXED_PRIO (g)
    ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .m0         (m0_bus),
      .m1         (m1_bus),
      .en_mem     (en_o[g]),
      .w_en_mem   (wen_o[g]),
      .addr_mem   (maddr_o[g]),
      .w_data_mem (mwdata_o[g]),
      .r_data_mem (mrdata_i[g])
    );

    // Behavioural single-port memory with byte enables and g+1 read latency.
    logic [DW-1:0] mem     [MEMW];
    logic [DW-1:0] rd_pipe [2];

    initial begin
      for (int i = 0; i < MEMW; i++) mem[i] <= mem_init(i);
    end

    always @(posedge clk) begin
      if (en_o[g]) begin
        if (wen_o[g] != '0) begin
          for (int b = 0; b < BW; b++) begin
            if (wen_o[g][b]) mem[maddr_o[g][9:2]][b*8 +: 8] <= mwdata_o[g][b*8 +: 8];
          end
        end else begin
          rd_pipe[0] <= mem[maddr_o[g][9:2]];
        end
      end
      rd_pipe[1] <= rd_pipe[0];
    end

    assign mrdata_i[g] = rd_pipe[g];
  end

  // One comparison: counted, and reported on mismatch.
  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cycle);
    end
  endtask

  task automatic applyStimulus(int k, int m, logic r, logic [BW-1:0] w,
                               logic [AW-1:0] a, logic [DW-1:0] d);
    req_in[k][m]   = r;
    we_in[k][m]    = w;
    addr_in[k][m]  = a;
    wdata_in[k][m] = d;
  endtask

  task automatic clearAll();
    for (int k = 0; k < NI; k++)
      for (int m = 0; m < 2; m++) applyStimulus(k, m, 1'b0, '0, '0, '0);
  endtask

  // Compare every output of both instances against the model, then advance
  // the model as if the coming clock edge had happened.
  task automatic checkOutput();
    for (int k = 0; k < NI; k++) begin
      int          win;
      int          hit;
      logic [1:0]  exp_gnt;
      logic [1:0]  exp_rv;
      logic [7:0]  word;
      win = -1;
      hit = -1;
      if (rstn) begin
        if (req_in[k] == 2'b11) win = (k == 1) ? 0 : 1 - last_win[k];
        else if (req_in[k][0])  win = 0;
        else if (req_in[k][1])  win = 1;
      end
      exp_gnt = (win >= 0) ? (2'b01 << win) : 2'b00;
      check($sformatf("i%0d_gnt", k), 64'(gnt_out[k]), 64'(exp_gnt));
      check($sformatf("i%0d_en", k), 64'(en_o[k]), 64'(win >= 0));
      if (win >= 0) begin
        check($sformatf("i%0d_addr", k), 64'(maddr_o[k]), 64'(addr_in[k][win]));
        check($sformatf("i%0d_wen", k), 64'(wen_o[k]), 64'(we_in[k][win]));
        if (we_in[k][win] != '0)
          check($sformatf("i%0d_wdata", k), 64'(mwdata_o[k]), 64'(wdata_in[k][win]));
      end else begin
        check($sformatf("i%0d_wen_idle", k), 64'(wen_o[k]), 64'd0);
      end

      exp_rv = 2'b00;
      foreach (exp_q[i]) if (exp_q[i].inst == k && exp_q[i].due == cycle) hit = i;
      if (hit >= 0) exp_rv = 2'b01 << exp_q[hit].id;
      check($sformatf("i%0d_rvalid", k), 64'(rvalid_out[k]), 64'(exp_rv));
      if (hit >= 0) begin
        check($sformatf("i%0d_rdata", k), 64'(rdata_out[k][exp_q[hit].id]), 64'(exp_q[hit].data));
        exp_q.delete(hit);
      end

      saw_gnt[k] = gnt_out[k];
      if (win >= 0) begin
        last_win[k] = win;
        word = addr_in[k][win][9:2];
        if (we_in[k][win] == '0) begin
          exp_q.push_back('{k, cycle + k + 1, win, ref_mem[k][word]});
        end else begin
          for (int b = 0; b < BW; b++)
            if (we_in[k][win][b]) ref_mem[k][word][b*8 +: 8] = wdata_in[k][win][b*8 +: 8];
        end
      end
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    cycle++;
    #1;
  endtask

  // Asserting reset drops every in-flight read and restores the tie-break.
  task automatic doReset();
    rstn = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NI; k++) last_win[k] = 1;
    runCycle();
    runCycle();
    rstn = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cycle = 0;
    rstn  = 1'b0;
    clearAll();
    for (int k = 0; k < NI; k++) begin
      last_win[k] = 1;
      saw_gnt[k]  = 2'b00;
      for (int i = 0; i < MEMW; i++) ref_mem[k][i] = mem_init(i);
    end

    // Reset state, then a lone master 0 read of 0x100.
    runCycle();
    runCycle();
    rstn = 1'b1;
    for (int k = 0; k < NI; k++) applyStimulus(k, 0, 1'b1, '0, 32'h100, '0);
    runCycle();
    clearAll();
    repeat (3) runCycle();

    // Both masters reading continuously from reset: alternation vs priority.
    doReset();
    for (int k = 0; k < NI; k++) begin
      applyStimulus(k, 0, 1'b1, '0, 32'h0, '0);
      applyStimulus(k, 1, 1'b1, '0, 32'h4, '0);
    end
    repeat (6) runCycle();
    for (int k = 0; k < NI; k++) applyStimulus(k, 0, 1'b0, '0, '0, '0);
    runCycle();
    clearAll();
    repeat (3) runCycle();

    // Partial write by master 1, then master 0 reads the same word.
    for (int k = 0; k < NI; k++) applyStimulus(k, 1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
    runCycle();
    clearAll();
    for (int k = 0; k < NI; k++) applyStimulus(k, 0, 1'b1, '0, 32'h20, '0);
    runCycle();
    clearAll();
    repeat (3) runCycle();

    // Back-to-back reads from different masters.
    for (int k = 0; k < NI; k++) applyStimulus(k, 0, 1'b1, '0, 32'h8, '0);
    runCycle();
    clearAll();
    for (int k = 0; k < NI; k++) applyStimulus(k, 1, 1'b1, '0, 32'hC, '0);
    runCycle();
    clearAll();
    repeat (3) runCycle();

    // Reset one cycle after a read grant, request held through reset.
    for (int k = 0; k < NI; k++) applyStimulus(k, 0, 1'b1, '0, 32'h100, '0);
    runCycle();
    doReset();
    for (int k = 0; k < NI; k++) applyStimulus(k, 1, 1'b1, '0, 32'h4, '0);
    runCycle();
    clearAll();
    repeat (3) runCycle();

    // Random traffic; each request is held until the master sees its grant.
    repeat (400) begin
      for (int k = 0; k < NI; k++) begin
        for (int m = 0; m < 2; m++) begin
          if (!req_in[k][m] || saw_gnt[k][m]) begin
            if ($urandom_range(0, 99) < 65)
              applyStimulus(k, m, 1'b1,
                            ($urandom_range(0, 1) != 0) ? BW'($urandom) : '0,
                            AW'($urandom_range(0, 15) * 4), DW'($urandom));
            else
              applyStimulus(k, m, 1'b0, '0, '0, '0);
          end
        end
      end
      runCycle();
    end
    clearAll();
    repeat (4) runCycle();

    check("drain_outstanding", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
